// File: rtl/logicnets_layer_seq.sv
// Sequential LogicNets layer: every neuron is evaluated in turn through one shared truth-table port.
// Optional build macro LUT_REGISTERED_EN: the shared LUT has one cycle of read latency, so one extra drain cycle is added.
module logicnets_layer_seq #(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_NEURONS = 8,
  parameter int FAN_IN      = 6,
  parameter int SEL_W       = $clog2(IN_WIDTH)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [IN_WIDTH-1:0]                         in_data,
  input  logic [NUM_NEURONS*FAN_IN*SEL_W-1:0]         conn_map,
  input  logic                                        flush,
  output logic [(NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1)-1:0] lut_sel,
  output logic [FAN_IN-1:0]                           lut_addr,
  input  logic                                        lut_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [NUM_NEURONS-1:0]                      out_data
);

  localparam int NSEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int IDX_W  = $clog2(NUM_NEURONS + 1);
`ifdef LUT_REGISTERED_EN
  localparam int LAST_IDX = NUM_NEURONS;
  localparam int WR_LAG   = 1;
`else
  localparam int LAST_IDX = NUM_NEURONS - 1;
  localparam int WR_LAG   = 0;
`endif

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                  state_reg;
  logic [IN_WIDTH-1:0]     frame_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [NUM_NEURONS-1:0]  out_data_reg;
  logic                    out_valid_reg;
  logic                    in_ready_reg;
  logic [NUM_NEURONS*FAN_IN-1:0] addr_flat;

  // Address bits of every neuron, gathered from the captured frame.
  // Out-of-range connectivity indices match no frame bit and so read as 0.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
      for (gk = 0; gk < FAN_IN; gk++) begin : g_bit
        logic [SEL_W-1:0] field;
        logic             bit_val;
        assign field = conn_map[(gi*FAN_IN + gk)*SEL_W +: SEL_W];
        always_comb begin
          bit_val = 1'b0;
          for (int j = 0; j < IN_WIDTH; j++) begin
            if (int'(field) == j) bit_val = frame_reg[j];
          end
        end
        assign addr_flat[gi*FAN_IN + gk] = bit_val;
      end
    end
  endgenerate

  // The drain cycle (idx == NUM_NEURONS) matches no neuron and presents zeros.
  always_comb begin
    lut_sel  = '0;
    lut_addr = '0;
    if (state_reg == EVAL) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (int'(idx_reg) == n) begin
          lut_sel  = NSEL_W'(n);
          lut_addr = addr_flat[n*FAN_IN +: FAN_IN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      frame_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else if (flush) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            frame_reg    <= in_data;
            out_data_reg <= '0;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= EVAL;
          end
        end
        EVAL: begin
          // With a registered LUT the data returning now belongs to the previous index.
          for (int n = 0; n < NUM_NEURONS; n++) begin
            if (int'(idx_reg) - WR_LAG == n) out_data_reg[n] <= lut_data;
          end
          if (int'(idx_reg) == LAST_IDX) begin
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_logicnets_layer_seq.sv
// Self-checking bench for logicnets_layer_seq: random truth tables and connectivity
// checked against a direct evaluation of the layer from its definition.
module tb_logicnets_layer_seq;

  localparam int IW = 16;
  localparam int NN = 8;
  localparam int FI = 6;
  localparam int SW = 5;
`ifdef LUT_REGISTERED_EN
  localparam int LAT = NN + 1;
`else
  localparam int LAT = NN;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_data;
  logic [NN*FI*SW-1:0] conn_map;
  logic              flush;
  logic [2:0]        lut_sel;
  logic [FI-1:0]     lut_addr;
  logic              lut_data;
  logic              out_valid;
  logic              out_ready;
  logic [NN-1:0]     out_data;

  logic [63:0] tt [NN];
  int          conn [NN][FI];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  logicnets_layer_seq #(.IN_WIDTH(IW), .NUM_NEURONS(NN), .FAN_IN(FI), .SEL_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .conn_map(conn_map), .flush(flush), .lut_sel(lut_sel), .lut_addr(lut_addr),
    .lut_data(lut_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // External truth-table memory, combinational or one-cycle registered.
`ifdef LUT_REGISTERED_EN
  always @(posedge clk) lut_data <= tt[lut_sel][lut_addr];
`else
  always_comb lut_data = tt[lut_sel][lut_addr];
`endif

  function automatic logic [FI-1:0] model_addr(int n, logic [IW-1:0] fr);
    logic [FI-1:0] a;
    a = '0;
    for (int k = 0; k < FI; k++) a[k] = (conn[n][k] < IW) ? fr[conn[n][k]] : 1'b0;
    return a;
  endfunction

  function automatic logic [NN-1:0] model_out(logic [IW-1:0] fr);
    logic [NN-1:0] r;
    for (int n = 0; n < NN; n++) r[n] = tt[n][model_addr(n, fr)];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pack_conn();
    for (int n = 0; n < NN; n++)
      for (int k = 0; k < FI; k++)
        conn_map[(n*FI + k)*SW +: SW] = SW'(conn[n][k]);
  endtask

  task automatic rand_net(input bit with31);
    for (int n = 0; n < NN; n++) begin
      tt[n] = {$urandom, $urandom};
      for (int k = 0; k < FI; k++)
        conn[n][k] = (with31 && $urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, IW-1));
    end
    pack_conn();
  endtask

  // After acceptance: check each presented address, latency and result.
  task automatic eval_and_check(input logic [IW-1:0] d);
    int cyc;
    cyc = 0;
    chk("in_ready_busy", in_ready, 0);
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (cyc < NN) begin
        chk("lut_sel", lut_sel, cyc);
        chk("lut_addr", lut_addr, model_addr(cyc, d));
      end
      tick();
      cyc++;
    end
    chk("latency", cyc, LAT);
    chk("out_data", out_data, model_out(d));
  endtask

  task automatic run_frame(input logic [IW-1:0] d, input int hold);
    logic [NN-1:0] res;
    chk("in_ready_idle", in_ready, 1);
    chk("lut_idle", {lut_sel, lut_addr}, 0);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    eval_and_check(d);
    res = out_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_data", out_data, res);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_ready", in_ready, 1);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_data", out_data, res);
  endtask

  initial begin
    logic [IW-1:0] d1, d2;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    rand_net(1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);

    // Identity truth tables: neuron n copies input bit n.
    for (int n = 0; n < NN; n++) begin
      tt[n] = 64'hAAAA_AAAA_AAAA_AAAA;
      conn[n][0] = n;
      for (int k = 1; k < FI; k++) conn[n][k] = (k == 3) ? 31 : int'($urandom_range(0, IW-1));
    end
    pack_conn();
    run_frame(16'h00A5, 0);
    chk("identity", out_data, 8'hA5);
    $display("identity frame 00A5 -> %02h", out_data);

    // Unreachable selector on every address bit of one neuron.
    rand_net(1'b1);
    for (int k = 0; k < FI; k++) conn[2][k] = 31;
    pack_conn();
    run_frame(16'hFFFF, 0);
    $display("all-31 neuron frame FFFF -> %02h", out_data);

    // Backpressure for 5 cycles.
    rand_net(1'b1);
    d1 = 16'($urandom);
    run_frame(d1, 5);
    $display("backpressure frame %04h -> %02h", d1, out_data);

    // Random frames and networks.
    for (int t = 0; t < 6; t++) begin
      rand_net(1'b1);
      d1 = 16'($urandom);
      run_frame(d1, int'($urandom_range(0, 2)));
      $display("random frame %04h -> %02h", d1, out_data);
    end

    // Flush while neuron 3 is being evaluated.
    d1 = 16'($urandom);
    in_valid = 1'b1; in_data = d1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("flush_at_idx", lut_sel, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_in_ready", in_ready, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_lut", {lut_sel, lut_addr}, 0);
    for (int i = 0; i < NN + 2; i++) begin
      tick();
      chk("flush_valid_stays", out_valid, 0);
    end
    d2 = 16'($urandom);
    run_frame(d2, 0);
    $display("flush then frame %04h -> %02h", d2, out_data);

    // Reset held 3 edges in the middle of EVAL.
    in_valid = 1'b1; in_data = 16'($urandom);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_eval_valid", out_valid, 0);
    chk("rst_eval_data", out_data, 0);
    chk("rst_eval_ready", in_ready, 1);
    $display("reset mid-eval -> ready=%0d valid=%0d", in_ready, out_valid);

    // Back-to-back frames with in_valid held high.
    rand_net(1'b1);
    d1 = 16'($urandom);
    d2 = 16'($urandom);
    in_valid = 1'b1; in_data = d1;
    tick();
    in_data = d2;
    eval_and_check(d1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_idle_ready", in_ready, 1);
    chk("b2b_first_kept", out_data, model_out(d1));
    tick();
    in_valid = 1'b0;
    eval_and_check(d2);
    $display("back-to-back %04h %04h -> %02h", d1, d2, out_data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("b2b_end_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logicnets_layer_seq.md
LOGICNETS_LAYER_SEQ -- requirements
Module: logicnets_layer_seq

Interface
REQ-001 Parameter IN_WIDTH, default 16: width of the layer input vector.
REQ-002 Parameter NUM_NEURONS, default 8: neurons in the layer, all evaluated through one shared LUT port.
REQ-003 Parameter FAN_IN, default 6: LUT address width per neuron.
REQ-004 Parameter SEL_W, default $clog2(IN_WIDTH): width of one connectivity index.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  input frame valid.
REQ-008 in_ready  out  1  block can accept a frame.
REQ-009 in_data  in  IN_WIDTH  input activation bits.
REQ-010 conn_map  in  NUM_NEURONS*FAN_IN*SEL_W  static connectivity; field [n][k] selects the in_data bit driving address bit k of neuron n.
REQ-011 flush  in  1  synchronous abort to IDLE.
REQ-012 lut_sel  out  $clog2(NUM_NEURONS)  neuron index presented to the shared LUT.
REQ-013 lut_addr  out  FAN_IN  truth-table address for neuron lut_sel.
REQ-014 lut_data  in  1  LUT output for {lut_sel, lut_addr}.
REQ-015 out_valid  out  1  layer result valid.
REQ-016 out_ready  in  1  downstream accepts the result.
REQ-017 out_data  out  NUM_NEURONS  neuron outputs; bit n = neuron n.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, EVAL and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-020 An IDLE edge with in_valid=1 SHALL capture in_data into a frame register, clear out_data, set the neuron index to 0 and enter EVAL.
REQ-021 In EVAL, lut_sel SHALL equal the neuron index, and lut_addr bit k SHALL equal frame[conn_map[idx][k]], driven combinationally from registered state.
REQ-022 A conn_map field value >= IN_WIDTH SHALL select bit value 0.
REQ-023 Without LUT_REGISTERED_EN, each EVAL edge SHALL write lut_data into out_data[idx] and increment idx; the edge with idx=NUM_NEURONS-1 SHALL enter DONE.
REQ-024 Outside EVAL, lut_sel and lut_addr SHALL be 0.
REQ-025 Latency: out_valid SHALL rise NUM_NEURONS edges after the accepting edge (LUT_REGISTERED_EN: NUM_NEURONS+1).
REQ-026 In DONE, out_valid=1 and out_data SHALL be held stable until an edge with out_ready=1, which SHALL return to IDLE; out_data SHALL persist after the handshake.
REQ-027 flush=1 SHALL force IDLE on that edge from any state, clear out_valid, discard partial results, and take priority over all handshakes on that edge.
REQ-028 NUM_NEURONS=1 SHALL produce a one-cycle EVAL.

Reset
REQ-029 rst=1 SHALL, on the edge, force IDLE with idx=0, frame=0, out_data=0, out_valid=0; in_ready SHALL be 1 from the first edge after rst deasserts.
REQ-030 rst SHALL take priority over flush and all handshakes, including mid-EVAL and in DONE.

Configuration
REQ-031 Macro LUT_REGISTERED_EN defined: lut_data is treated as one-cycle-latency (registered ROM); addresses issue on consecutive edges, and lut_data is written to out_data[idx-1] one edge later, with an extra drain cycle before DONE.
REQ-032 Macro LUT_REGISTERED_EN undefined: lut_data is combinational and is sampled on the same edge as its address, per REQ-023.

Verification
REQ-033 Reset: rst held for 3 edges during EVAL -> out_valid=0, out_data=0, in_ready=1 after release.
REQ-034 Identity LUT model (lut_data = lut_addr[0]), conn_map[n][0]=n, in_data=16'h00A5 -> out_data=8'hA5, out_valid rising 8 edges after acceptance (9 with LUT_REGISTERED_EN).
REQ-035 Backpressure: out_ready=0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout; the out_ready=1 edge returns to IDLE.
REQ-036 flush asserted at idx=3 -> IDLE on the next edge, out_valid stays 0; the next frame yields the correct full result.
REQ-037 Back-to-back frames with in_valid held high -> second accepted on the first IDLE edge after the out handshake; the results are independent.
REQ-038 conn_map field=31 with IN_WIDTH=16 -> the corresponding lut_addr bit reads 0.
